// File: rtl/perf_pkg.sv
// Shared encodings for the performance counter bank.
// CTRL bit positions, register field selects and core event numbering.
package perf_pkg;

  typedef enum logic [1:0] {
    FLD_CTRL  = 2'd0,
    FLD_VALUE = 2'd1,
    FLD_SNAP  = 2'd2,
    FLD_RSVD  = 2'd3
  } fld_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_SAT     = 1;
  localparam int CTRL_OVF     = 2;
  localparam int CTRL_IE      = 3;
  localparam int CTRL_SEL_LSB = 8;

  localparam int EVT_CYCLE        = 0;
  localparam int EVT_INSTR        = 1;
  localparam int EVT_MEM_RD       = 2;
  localparam int EVT_MEM_WR       = 3;
  localparam int EVT_RF_RD        = 4;
  localparam int EVT_RF_WR        = 5;
  localparam int EVT_BRANCH_TAKEN = 6;
  localparam int EVT_JUMP         = 7;

endpackage

// File: rtl/perf_counter_slice.sv
// One performance counter: value, CTRL, sticky overflow, optional shadow.
// Shadow storage exists only when PERF_SNAPSHOT_EN is defined.
module perf_counter_slice
  import perf_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int NUM_EVT   = 16,
  parameter int EVT_SEL_W = $clog2(NUM_EVT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_halt,
  input  logic [NUM_EVT-1:0] i_evt,
  input  logic               i_we_ctrl,
  input  logic               i_we_value,
  input  logic [CNT_W-1:0]   i_wdata,
`ifdef PERF_SNAPSHOT_EN
  input  logic               i_snap_req,
`endif
  output logic [CNT_W-1:0]   o_value,
  output logic [CNT_W-1:0]   o_ctrl,
  output logic [CNT_W-1:0]   o_shadow,
  output logic               o_irq
);

  localparam int EVT_PAD = 1 << EVT_SEL_W;

  logic [CNT_W-1:0]     r_value;
  logic                 r_en;
  logic                 r_sat;
  logic                 r_ovf;
  logic                 r_ie;
  logic [EVT_SEL_W-1:0] r_sel;

  logic [EVT_PAD-1:0]   w_evt_pad;
  logic                 w_hit;
  logic                 w_max;
  logic [CNT_W-1:0]     w_value_nxt;
  logic                 w_ovf_nxt;

  // Unimplemented selects pad with zeros, so they never count.
  assign w_evt_pad = EVT_PAD'(i_evt);
  assign w_hit     = r_en & ~i_halt & w_evt_pad[r_sel];
  assign w_max     = &r_value;

  // Next value and overflow; a VALUE write suppresses the increment.
  always_comb begin
    w_value_nxt = r_value;
    w_ovf_nxt   = r_ovf;
    if (i_we_ctrl && i_wdata[CTRL_OVF]) begin
      w_ovf_nxt = 1'b0;
    end
    if (i_we_value) begin
      w_value_nxt = i_wdata;
    end else if (w_hit) begin
      if (w_max) begin
        w_ovf_nxt   = 1'b1;
        w_value_nxt = r_sat ? r_value : '0;
      end else begin
        w_value_nxt = r_value + 1'b1;
      end
    end
  end

  // Counter state; clear zeroes value/ovf but keeps configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
      r_ovf   <= 1'b0;
      r_en    <= 1'b0;
      r_sat   <= 1'b0;
      r_ie    <= 1'b0;
      r_sel   <= '0;
    end else begin
      if (i_we_ctrl) begin
        r_en  <= i_wdata[CTRL_EN];
        r_sat <= i_wdata[CTRL_SAT];
        r_ie  <= i_wdata[CTRL_IE];
        r_sel <= i_wdata[CTRL_SEL_LSB +: EVT_SEL_W];
      end
      if (i_clear) begin
        r_value <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_value <= w_value_nxt;
        r_ovf   <= w_ovf_nxt;
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] r_shadow;

  // Shadow captures the pre-increment value on a snapshot request.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_shadow <= '0;
    end else if (i_snap_req) begin
      r_shadow <= r_value;
    end
  end

  assign o_shadow = r_shadow;
`else
  assign o_shadow = '0;
`endif

  // CTRL read image; unused bits read as zero.
  always_comb begin
    o_ctrl                               = '0;
    o_ctrl[CTRL_EN]                      = r_en;
    o_ctrl[CTRL_SAT]                     = r_sat;
    o_ctrl[CTRL_OVF]                     = r_ovf;
    o_ctrl[CTRL_IE]                      = r_ie;
    o_ctrl[CTRL_SEL_LSB +: EVT_SEL_W]    = r_sel;
  end

  assign o_value = r_value;
  assign o_irq   = r_ovf & r_ie;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT performance counters with indexed register access.
// Snapshot shadows are built only when PERF_SNAPSHOT_EN is defined.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT   = 8,
  parameter int CNT_W     = 32,
  parameter int NUM_EVT   = 16,
  parameter int EVT_SEL_W = $clog2(NUM_EVT),
  localparam int IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clear_all,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [1:0]         cfg_field,
  input  logic [CNT_W-1:0]   cfg_wdata,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [1:0]         rd_field,
  output logic [CNT_W-1:0]   rd_data,
  input  logic               snap_req,
  output logic               snap_valid,
  output logic               irq
);

  logic [CNT_W-1:0]   w_val  [NUM_CNT];
  logic [CNT_W-1:0]   w_ctrl [NUM_CNT];
  logic [CNT_W-1:0]   w_shd  [NUM_CNT];
  logic [NUM_CNT-1:0] w_irq;
  logic [NUM_CNT-1:0] w_we_ctrl;
  logic [NUM_CNT-1:0] w_we_value;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    assign w_we_ctrl[g]  = cfg_we && (cfg_field == FLD_CTRL)
                        && (cfg_idx == IDX_W'(g));
    assign w_we_value[g] = cfg_we && (cfg_field == FLD_VALUE)
                        && (cfg_idx == IDX_W'(g));

    perf_counter_slice #(
      .CNT_W     (CNT_W),
      .NUM_EVT   (NUM_EVT),
      .EVT_SEL_W (EVT_SEL_W)
    ) u_slice (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (clear_all),
      .i_halt     (halt),
      .i_evt      (evt),
      .i_we_ctrl  (w_we_ctrl[g]),
      .i_we_value (w_we_value[g]),
      .i_wdata    (cfg_wdata),
`ifdef PERF_SNAPSHOT_EN
      .i_snap_req (snap_req),
`endif
      .o_value    (w_val[g]),
      .o_ctrl     (w_ctrl[g]),
      .o_shadow   (w_shd[g]),
      .o_irq      (w_irq[g])
    );
  end

`ifdef PERF_SNAPSHOT_EN
  logic r_snap_valid;

  // Snapshot held flag; clear_all beats a same-cycle request.
  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      r_snap_valid <= 1'b0;
    end else if (snap_req) begin
      r_snap_valid <= 1'b1;
    end
  end

  assign snap_valid = r_snap_valid;
`else
  logic w_unused_snap;
  assign w_unused_snap = snap_req;
  assign snap_valid    = 1'b0;
`endif

  // Read mux; unmatched index or reserved field returns zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        case (rd_field)
          FLD_CTRL:  rd_data = w_ctrl[i];
          FLD_VALUE: rd_data = w_val[i];
          FLD_SNAP:  rd_data = w_shd[i];
          default:   rd_data = '0;
        endcase
      end
    end
  end

  assign irq = |w_irq;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (6 x 16-bit, 12 events).
// Directed steps followed by randomized traffic against a reference model.
module tb_perf_counter_bank;

  localparam int NC   = 6;
  localparam int W    = 16;
  localparam int NE   = 12;
  localparam int IW   = $clog2(NC);
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NE-1:0] evt;
  logic          halt;
  logic          clear_all;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [1:0]    cfg_field;
  logic [W-1:0]  cfg_wdata;
  logic [IW-1:0] rd_idx;
  logic [1:0]    rd_field;
  logic [W-1:0]  rd_data;
  logic          snap_req;
  logic          snap_valid;
  logic          irq;

  always #50 clk = ~clk;

  perf_counter_bank #(
    .NUM_CNT (NC),
    .CNT_W   (W),
    .NUM_EVT (NE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .evt        (evt),
    .halt       (halt),
    .clear_all  (clear_all),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_field  (cfg_field),
    .cfg_wdata  (cfg_wdata),
    .rd_idx     (rd_idx),
    .rd_field   (rd_field),
    .rd_data    (rd_data),
    .snap_req   (snap_req),
    .snap_valid (snap_valid),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;

  int m_val [NC];
  int m_en  [NC];
  int m_sat [NC];
  int m_ovf [NC];
  int m_ie  [NC];
  int m_sel [NC];
  int m_shd [NC];
  int m_sv;

  // Reference model: applies one clock edge of the architectural rules.
  function automatic void model_step();
    int  v, o, wd;
    bit  wc, wv, hit;
    wd = int'(cfg_wdata);
    for (int c = 0; c < NC; c++) begin
      if (reset) begin
        m_val[c] = 0; m_ovf[c] = 0; m_en[c] = 0;
        m_sat[c] = 0; m_ie[c] = 0; m_sel[c] = 0; m_shd[c] = 0;
      end else begin
        wc  = cfg_we && cfg_field == 2'd0 && int'(cfg_idx) == c;
        wv  = cfg_we && cfg_field == 2'd1 && int'(cfg_idx) == c;
        hit = m_en[c] == 1 && !halt && m_sel[c] < NE
           && ((evt >> m_sel[c]) & 1) != 0;
        v = m_val[c];
        o = m_ovf[c];
        if (wc && (wd & 4) != 0) o = 0;
        if (wv) v = wd;
        else if (hit) begin
          if (v == MAXV) begin
            o = 1;
            if (m_sat[c] == 0) v = 0;
          end else v = v + 1;
        end
`ifdef PERF_SNAPSHOT_EN
        if (snap_req) m_shd[c] = m_val[c];
`endif
        if (clear_all) begin
          v = 0; o = 0; m_shd[c] = 0;
        end
        if (wc) begin
          m_en[c]  = wd & 1;
          m_sat[c] = (wd >> 1) & 1;
          m_ie[c]  = (wd >> 3) & 1;
          m_sel[c] = (wd >> 8) & 15;
        end
        m_val[c] = v;
        m_ovf[c] = o;
      end
    end
    if (reset || clear_all) m_sv = 0;
`ifdef PERF_SNAPSHOT_EN
    else if (snap_req) m_sv = 1;
`endif
  endfunction

  function automatic int exp_rd(int idx, int f);
    if (idx >= NC) return 0;
    case (f)
      0: return m_en[idx] | (m_sat[idx] << 1) | (m_ovf[idx] << 2)
              | (m_ie[idx] << 3) | (m_sel[idx] << 8);
      1: return m_val[idx];
      2: return m_shd[idx];
      default: return 0;
    endcase
  endfunction

  function automatic int exp_irq();
    int r = 0;
    for (int c = 0; c < NC; c++) r |= m_ovf[c] & m_ie[c];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx, input int f, output logic [31:0] v);
    rd_idx   = IW'(idx);
    rd_field = 2'(f);
    #1;
    v = 32'(rd_data);
  endtask

  task automatic wr(input int idx, input int f, input int data);
    cfg_we    = 1'b1;
    cfg_idx   = IW'(idx);
    cfg_field = 2'(f);
    cfg_wdata = W'(data);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    for (int i = 0; i < (1 << IW); i++) begin
      for (int f = 0; f < 4; f++) begin
        rd(i, f, v);
        chk($sformatf("%s_i%0d_f%0d", tag, i, f), v, 32'(exp_rd(i, f)));
      end
    end
    chk({tag, "_irq"}, 32'(irq), 32'(exp_irq()));
    chk({tag, "_snapv"}, 32'(snap_valid), 32'(m_sv));
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; evt = '0; halt = 1'b0; clear_all = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
    rd_idx = '0; rd_field = '0; snap_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_all("reset");
    chk("reset_irq_lit", 32'(irq), 32'd0);

    // Count cycles on event 0, then freeze under halt.
    wr(0, 0, 32'h0001);
    evt = NE'(1);
    repeat (10) tick();
    rd(0, 1, v); chk("t1_count10", v, 32'd10);
    halt = 1'b1;
    repeat (5) tick();
    rd(0, 1, v); chk("t1_halt", v, 32'd10);
    check_all("t1");
    halt = 1'b0; evt = '0;

    // Wrap overflow with interrupt, then W1C.
    wr(1, 1, 32'hFFFE);
    wr(1, 0, 32'h0209);
    evt = NE'(4); tick(); evt = '0; tick();
    rd(1, 1, v); chk("t2_ffff", v, 32'hFFFF);
    chk("t2_irq_pre", 32'(irq), 32'd0);
    evt = NE'(4); tick(); evt = '0;
    rd(1, 1, v); chk("t2_wrap0", v, 32'h0);
    chk("t2_irq_rise", 32'(irq), 32'd1);
    tick();
    evt = NE'(4); tick(); evt = '0;
    rd(1, 1, v); chk("t2_val1", v, 32'h1);
    rd(1, 0, v); chk("t2_ctrl_ovf", v, 32'h020D);
    wr(1, 0, 32'h020D);
    rd(1, 0, v); chk("t2_ctrl_w1c", v, 32'h0209);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    check_all("t2");

    // Saturation and overflow-set beating W1C.
    wr(2, 1, 32'hFFFF);
    wr(2, 0, 32'h0303);
    repeat (4) begin
      evt = NE'(8); tick(); evt = '0; tick();
    end
    rd(2, 1, v); chk("t3_sat", v, 32'hFFFF);
    rd(2, 0, v); chk("t3_ovf", v, 32'h0307);
    wr(2, 0, 32'h0307);
    rd(2, 0, v); chk("t3_w1c", v, 32'h0303);
    evt = NE'(8);
    wr(2, 0, 32'h0307);
    evt = '0;
    rd(2, 0, v); chk("t3_set_wins", v, 32'h0307);
    check_all("t3");

    // VALUE write beats increment; clear_all beats VALUE write.
    evt = NE'(1);
    wr(0, 1, 32'h1234);
    evt = '0;
    rd(0, 1, v); chk("t4_wr_no_inc", v, 32'h1234);
    clear_all = 1'b1;
    wr(0, 1, 32'h5555);
    clear_all = 1'b0;
    rd(0, 1, v); chk("t4_clear", v, 32'h0);
    check_all("t4");

    // Unimplemented event select and out-of-range index.
    wr(3, 0, 1 | ((NE + 1) << 8));
    evt = '1;
    repeat (5) tick();
    evt = '0;
    rd(3, 1, v); chk("t5_bad_sel", v, 32'h0);
    wr(6, 1, 32'h7777);
    wr(7, 0, 32'h0001);
    rd(6, 1, v); chk("t5_rd_oor6", v, 32'h0);
    rd(7, 0, v); chk("t5_rd_oor7", v, 32'h0);
    rd(0, 3, v); chk("t5_rsvd", v, 32'h0);
    check_all("t5");

    // Snapshot capture and clear.
    wr(4, 1, 5);
    wr(5, 1, 9);
    wr(4, 0, 32'h0001);
    wr(5, 0, 32'h0001);
    evt = NE'(1); snap_req = 1'b1;
    tick();
    evt = '0; snap_req = 1'b0;
    rd(4, 1, v); chk("t6_val4", v, 32'd6);
    rd(5, 1, v); chk("t6_val5", v, 32'd10);
`ifdef PERF_SNAPSHOT_EN
    rd(4, 2, v); chk("t6_snap4", v, 32'd5);
    rd(5, 2, v); chk("t6_snap5", v, 32'd9);
    chk("t6_snapv", 32'(snap_valid), 32'd1);
`else
    rd(4, 2, v); chk("t6_snap4_off", v, 32'd0);
    chk("t6_snapv_off", 32'(snap_valid), 32'd0);
`endif
    clear_all = 1'b1; snap_req = 1'b1;
    tick();
    clear_all = 1'b0; snap_req = 1'b0;
    rd(5, 2, v); chk("t6_snap_clr", v, 32'd0);
    chk("t6_snapv_clr", 32'(snap_valid), 32'd0);
    check_all("t6");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      evt       = NE'($urandom);
      halt      = ($urandom_range(0, 7) == 0);
      clear_all = ($urandom_range(0, 31) == 0);
      snap_req  = ($urandom_range(0, 15) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_idx   = IW'($urandom_range(0, (1 << IW) - 1));
      cfg_field = 2'($urandom_range(0, 3));
      if (cfg_field == 2'd1 && $urandom_range(0, 1) == 0)
        cfg_wdata = W'(MAXV - $urandom_range(0, 3));
      else if (cfg_field == 2'd0)
        cfg_wdata = W'($urandom & 32'h0F0F);
      else
        cfg_wdata = W'($urandom);
      tick();
      check_all($sformatf("rnd%0d", n));
    end

    // Reset in the middle of activity.
    reset = 1'b1;
    tick();
    reset = 1'b0; clear_all = 1'b0; snap_req = 1'b0;
    cfg_we = 1'b0; evt = '0; halt = 1'b0;
    check_all("rst_mid");
    rd(1, 0, v); chk("rst_mid_ctrl", v, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of NUM_CNT hardware performance counters for the RV32 core.
- Supersedes the fixed cycle, instruction, memory and register-file counters hard-coded in the core.
- Each counter selects one of NUM_EVT single-bit event strobes driven by the core. It can be enabled, set to wrap or saturate, flags overflow with an optional interrupt, and freezes while the core is halted.
- Software/debug access is a simple indexed register port.

Parameters:
- NUM_CNT, 8: number of counters (1..16).
- CNT_W, 32: counter width in bits (16..64).
- NUM_EVT, 16: number of event inputs (2..256).
- EVT_SEL_W, $clog2(NUM_EVT): width of the event-select field (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset; clock clk.
- evt  in  NUM_EVT  per-cycle event strobes; bit k high = event k occurred this cycle.
- halt  in  1  core halted; all counting frozen while high.
- clear_all  in  1  pulse: zero all counter values and overflow flags.
- cfg_we  in  1  register write strobe.
- cfg_idx  in  $clog2(NUM_CNT)  target counter for write.
- cfg_field  in  2  0=CTRL, 1=VALUE, 2=SNAPSHOT (read-only), 3=reserved.
- cfg_wdata  in  CNT_W  write data.
- rd_idx  in  $clog2(NUM_CNT)  read counter index.
- rd_field  in  2  read field select (same encoding as cfg_field).
- rd_data  out  CNT_W  combinational read data.
- snap_req  in  1  pulse: capture all counter values.
- snap_valid  out  1  a snapshot is held.
- irq  out  1  OR of (ovf & irq_en) over all counters.

Behaviour:
- CTRL layout:
  - bit0 en.
  - bit1 sat (1 = saturate, 0 = wrap).
  - bit2 ovf: sticky flag; writing 1 clears it, writing 0 leaves it.
  - bit3 irq_en.
  - bits[8 +: EVT_SEL_W] evt_sel.
  - All other bits read 0.
- Reset: all values, CTRL fields, ovf and snapshots are 0; snap_valid=0; irq=0.
- Increment, evaluated per counter per cycle:
  - Increment when en && !halt && evt_sel<NUM_EVT && evt[evt_sel]. The counter increments by 1 and the new value is visible the next cycle.
  - evt_sel >= NUM_EVT never counts.
- Overflow:
  - Applies when an increment occurs at value 2^CNT_W-1.
  - Wrap mode: value becomes 0 and ovf is set.
  - Sat mode: value holds at max and ovf is set.
  - An increment while already at max in sat mode re-sets ovf.
- irq is combinational from registered state, so it rises the cycle after the overflowing edge.
- Priority per counter, highest first:
  1. reset.
  2. clear_all: values=0, ovf=0; CTRL en/sat/irq_en/evt_sel are kept.
  3. cfg write to VALUE: loads cfg_wdata and suppresses that cycle's increment.
  4. Increment.
- CTRL write coinciding with an overflow: ovf ends set, i.e. set wins over the W1C.
- CTRL write takes effect for counting the following cycle. The same-cycle increment uses the old CTRL.
- Writes with cfg_field 2 or 3, or with cfg_idx >= NUM_CNT, are ignored.
- Reads:
  - Out-of-range index or field 3 returns 0.
  - A VALUE read returns the registered value, pre-increment.
- halt freezes counting only; register access still works.
- Reset mid-operation discards everything, with no partial state.

Optional Feature:
- Macro PERF_SNAPSHOT_EN.
- Defined:
  - snap_req copies every counter's registered value (pre-increment in that cycle) into a shadow register.
  - snap_valid is set the next cycle and stays set until reset or clear_all; clear_all zeroes the shadows.
  - rd_field=2 returns the shadow.
  - snap_req and clear_all in the same cycle: clear_all wins.
- Undefined: no shadow storage; snap_req is ignored; snap_valid ties to 0; field 2 reads 0.

Decomposition:
- Package perf_pkg holds:
  - Field encodings FLD_CTRL/FLD_VALUE/FLD_SNAP.
  - CTRL bit positions CTRL_EN, CTRL_SAT, CTRL_OVF, CTRL_IE, CTRL_SEL_LSB.
  - Default event numbering used by the core: EVT_CYCLE=0, EVT_INSTR=1, EVT_MEM_RD=2, EVT_MEM_WR=3, EVT_RF_RD=4, EVT_RF_WR=5, EVT_BRANCH_TAKEN=6, EVT_JUMP=7.
- Sub-module perf_counter_slice:
  - Contains one counter: value, CTRL, ovf and shadow.
  - Instantiated NUM_CNT times by generate.
  - The top level holds address decode, the read mux and the irq OR.

Test Plan:
1. Reset, then write CTRL[0]=0x0001 (en, evt_sel=0), hold evt[0]=1 for 10 cycles → VALUE[0]=10; halt=1 for 5 more cycles → still 10.
2. CNT_W=16, wrap: VALUE[1]=0xFFFE, CTRL=en|ie, evt_sel=2, evt[2] pulsed 3 times → value 0x0001; ovf=1; irq rises the cycle after the 0xFFFF→0 edge; write CTRL with bit2=1 → ovf=0, irq=0.
3. Sat: VALUE=0xFFFF, sat|en, event pulsed 4 times → value 0xFFFF, ovf=1; CTRL W1C in the same cycle as an overflow → ovf remains 1.
4. VALUE write of 0x1234 coinciding with a selected event → reads 0x1234 (not 0x1235); clear_all coinciding with VALUE write → 0.
5. evt_sel=NUM_EVT+1 with all evt high → no count; cfg_idx=NUM_CNT write → no counter changes; rd out of range → 0.
6. PERF_SNAPSHOT_EN: counters at 5 and 9, snap_req with events active → SNAPSHOT reads 5/9 while VALUE reads 6/10, snap_valid=1; clear_all → shadows 0 and snap_valid=0. Without the macro, field 2 reads 0.
